// File: rtl/rdoq_level_pkg.sv
// Shared types for the CABAC level reconstruction path: level classes and FIFO entry layout.
package rdoq_level_pkg;

    typedef enum logic [1:0] {
        LVL_ZERO,
        LVL_ONE,
        LVL_TWO,
        LVL_BASEPLUS
    } level_case_e;

    localparam int unsigned MIN_BASEPLUS = 3;

    typedef struct packed {
        logic [15:0] abs_level;
        logic        last;
        logic        err;
    } level_entry_t;

endpackage

// File: rtl/level_recon_fifo.sv
// DEPTH-entry synchronous FIFO of level entries; head is shown combinationally from storage.
module level_recon_fifo
    import rdoq_level_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  level_entry_t                   wr_data,
    input  logic                           pop,
    output level_entry_t                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);

    level_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/level_reconstructor.sv
// Rebuilds uiAbsLevel from (level_case, symbol, baseLevel), queues it, and keeps per-block stats.
module level_reconstructor
    import rdoq_level_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 11,
    parameter int unsigned SUM_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       level_case,
    input  logic [15:0]      symbol,
    input  logic [7:0]       baseLevel,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      abs_level,
    output logic             out_last,
    output logic             out_err,
    output logic             blk_done,
    output logic [CNT_W-1:0] blk_nz_count,
    output logic [SUM_W-1:0] blk_sum
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    level_case_e      lc;
    logic [16:0]      sum17;
    logic [15:0]      rec_level;
    logic             rec_err;
    level_entry_t     wr_entry;
    level_entry_t     head;
    logic [CW-1:0]    count;
    logic             alive;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] nz_acc;
    logic [CNT_W-1:0] nz_next;
    logic [SUM_W-1:0] sum_acc;
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W:0]   sum_wide;

    assign lc    = level_case_e'(level_case);
    assign sum17 = {1'b0, symbol} + {9'b0, baseLevel};

    always_comb begin
        rec_level = '0;
        rec_err   = 1'b0;
        unique case (lc)
            LVL_ZERO: rec_level = 16'd0;
            LVL_ONE:  rec_level = 16'd1;
            LVL_TWO:  rec_level = 16'd2;
            LVL_BASEPLUS: begin
                if (sum17[16]) begin
                    rec_level = '1;
                    rec_err   = 1'b1;
                end else begin
                    rec_level = sum17[15:0];
                    rec_err   = (sum17 < 17'(MIN_BASEPLUS));
                end
            end
            default: ;
        endcase
    end

    // alive keeps in_ready low while in reset even though count is already zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    assign in_ready  = alive && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_entry.abs_level = rec_level;
    assign wr_entry.last      = in_last;
    assign wr_entry.err       = rec_err;

    level_recon_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .count   (count)
    );

    assign abs_level = head.abs_level;
    assign out_last  = head.last;
    assign out_err   = head.err;

    always_comb begin
        nz_next = nz_acc;
        if ((rec_level != '0) && (nz_acc != '1)) begin
            nz_next = nz_acc + 1'b1;
        end
        sum_wide = {1'b0, sum_acc} + (SUM_W + 1)'(rec_level);
        sum_next = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_acc       <= '0;
            sum_acc      <= '0;
            blk_done     <= 1'b0;
            blk_nz_count <= '0;
            blk_sum      <= '0;
        end else begin
            blk_done <= accept && in_last;
            if (accept) begin
                if (in_last) begin
                    blk_nz_count <= nz_next;
                    blk_sum      <= sum_next;
                    nz_acc       <= '0;
                    sum_acc      <= '0;
                end else begin
                    nz_acc  <= nz_next;
                    sum_acc <= sum_next;
                end
            end
        end
    end

endmodule

// File: doc/level_reconstructor.md
Name: level_reconstructor

Overview:
- Inverse of the CABAC estimator's level classification: rebuilds uiAbsLevel from a (level_case, symbol, baseLevel) triple.
- Used by the RDOQ checker path and for decode-side verification of estimator outputs.
- Streaming valid/ready input, small output FIFO, per-block statistics (nonzero count, level sum) on a last-coefficient marker.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, >= 2.
- CNT_W, 11, width of per-block nonzero counter (covers 1024 coefficients of a 32x32 TU).
- SUM_W, 24, width of per-block saturating level sum.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input triple valid.
- in_ready  out  1  block can accept a triple.
- level_case  in  2  0 ZERO, 1 ONE, 2 TWO, 3 BASEPLUS.
- symbol  in  16  remainder above baseLevel; only meaningful for BASEPLUS.
- baseLevel  in  8  base level used by the classifier.
- in_last  in  1  last coefficient of the current block.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- abs_level  out  16  reconstructed absolute level.
- out_last  out  1  in_last carried with the entry.
- out_err  out  1  entry flagged (overflow or illegal BASEPLUS).
- blk_done  out  1  one-cycle pulse after a block closes.
- blk_nz_count  out  CNT_W  nonzero levels in the last closed block.
- blk_sum  out  SUM_W  saturated sum of abs_level in the last closed block.

Behaviour:
- Reset (async, rst_n low): all of the following are 0 and any in-flight data is discarded.
  - in_ready, out_valid, abs_level, out_last, out_err.
  - blk_done, blk_nz_count, blk_sum.
  - FIFO pointers, FIFO count, internal accumulators.
- in_ready is 1 from the first cycle after reset release.
- Accept occurs when in_valid && in_ready.
- in_ready = (fifo_count < DEPTH). It is a function of registered count only; there is no combinational path from out_ready.
- Reconstruction is combinational on accept; the result is written into the FIFO on the same edge.
  - ZERO -> 0; ONE -> 1; TWO -> 2; symbol ignored.
  - BASEPLUS -> symbol + baseLevel, computed at 17 bits.
  - If the 17-bit sum > 0xFFFF: abs_level = 0xFFFF, err = 1.
  - If the sum < 3: err = 1 and the value is kept unchanged, because the classifier never emits BASEPLUS below 3.
- Latency: an accepted triple appears at out_valid the next cycle when the FIFO was empty. Ordering is strict FIFO.
- Pop occurs when out_valid && out_ready. abs_level, out_last and out_err show the head entry and are stable while out_valid && !out_ready.
- Simultaneous push and pop: count is unchanged.
  - At count == DEPTH, no push is possible (in_ready = 0); a pop still proceeds and in_ready rises the next cycle.
  - At count == 0, no pop is possible; a push makes out_valid = 1 the next cycle.
- Pointers wrap modulo DEPTH.
- Block statistics are updated on accept, not on pop:
  - nz_acc increments when the reconstructed level != 0; it saturates at all-ones.
  - sum_acc += abs_level, saturating at 2^SUM_W - 1.
- Accept with in_last = 1 closes the block:
  - On that edge, blk_nz_count and blk_sum load the final values, including the current coefficient.
  - blk_done = 1 for exactly the next cycle.
  - Accumulators clear to 0 on the same edge.
  - Back-to-back in_last accepts give consecutive blk_done pulses, each with its own block's values.
- blk_nz_count and blk_sum hold their values until the next block closes.
- A single-coefficient block (in_last on the first accept) is legal.
- Inputs are ignored when !(in_valid && in_ready). Upstream must hold the triple stable while in_valid && !in_ready.

Decomposition:
- Package rdoq_level_pkg contains:
  - typedef enum logic [1:0] level_case_e {LVL_ZERO, LVL_ONE, LVL_TWO, LVL_BASEPLUS}.
  - localparam MIN_BASEPLUS = 3.
  - typedef struct packed {abs_level[15:0], last, err} level_entry_t.
- One sub-module, level_recon_fifo: generic DEPTH-entry synchronous FIFO of level_entry_t with count output, async active-low reset.
- Reconstruction and statistics live in the top module.

Test Plan:
- Reset then stream ZERO, ONE, TWO, BASEPLUS(sym=5, base=3), out_ready=1 -> abs_level 0, 1, 2, 8 one cycle after each accept, err = 0.
- BASEPLUS sym=0xFFF0, base=0x20 -> abs_level 0xFFFF, out_err = 1; BASEPLUS sym=0, base=1 -> abs_level 1, out_err = 1.
- out_ready=0, push 3 items -> in_ready falls after 2 accepts; third is held. Raise out_ready -> outputs in order, and in_ready returns the cycle after the first pop.
- Block of 4 levels {3, 0, 1, 7} with in_last on the 4th -> blk_done pulse 1 cycle later, blk_nz_count = 3, blk_sum = 11. The next block starts from 0.
- Two consecutive single-coefficient blocks (levels 2 then 0) -> two adjacent blk_done pulses with (1, 2) then (0, 0).
- Assert rst_n low with 2 entries queued and a partial block -> out_valid = 0, blk_* = 0 immediately. After release the first new item outputs normally with accumulators starting from 0.
